// File: rtl/ppc_wb_trace_tx_pkg.sv
// Shared types, header layout and helpers for the architectural-write trace transmitter.
package ppc_wb_trace_tx_pkg;

    localparam logic [2:0] TRC_KIND_GPR = 3'd0;
    localparam logic [2:0] TRC_KIND_CR  = 3'd1;
    localparam logic [2:0] TRC_KIND_MSR = 3'd2;
    localparam logic [2:0] TRC_KIND_SPR = 3'd3;
    localparam logic [2:0] TRC_KIND_DM  = 3'd4;

    localparam int TRC_HDR_OVF_BIT  = 31;
    localparam int TRC_HDR_KIND_MSB = 30;
    localparam int TRC_HDR_KIND_LSB = 28;
    localparam int TRC_HDR_IDX_MSB  = 27;
    localparam int TRC_HDR_IDX_LSB  = 18;
    localparam int TRC_HDR_SEQ_MSB  = 15;
    localparam int TRC_HDR_SEQ_LSB  = 0;
    localparam int TRC_IDX_W        = 10;

    // Slot number equals the flag bit position and the emission order.
    localparam logic [2:0] SLOT_GPR  = 3'd0;
    localparam logic [2:0] SLOT_CR   = 3'd1;
    localparam logic [2:0] SLOT_MSR  = 3'd2;
    localparam logic [2:0] SLOT_SPR0 = 3'd3;
    localparam logic [2:0] SLOT_SPR1 = 3'd4;
    localparam logic [2:0] SLOT_DM   = 3'd5;

    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_INSTR, ST_VAL, ST_ADDR} trc_state_t;

    typedef struct packed {
        logic [5:0]           flags;
        logic [31:0]          instr_w;
        logic [31:0]          instr_m;
        logic [4:0]           gpr_waddr;
        logic [31:0]          gpr_wd;
        logic [31:0]          cr_wd;
        logic [31:0]          msr_wd;
        logic [TRC_IDX_W-1:0] spr_waddr0;
        logic [31:0]          spr_wd0;
        logic [TRC_IDX_W-1:0] spr_waddr1;
        logic [31:0]          spr_wd1;
        logic [31:0]          dm_addr;
        logic [31:0]          dm_wd;
    } trc_bundle_t;

    localparam int TRC_BUNDLE_W = $bits(trc_bundle_t);

    function automatic logic [31:0] make_hdr(input logic ovf, input logic [2:0] kind,
                                             input logic [TRC_IDX_W-1:0] idx, input logic [15:0] seq);
        logic [31:0] h;
        h = 32'd0;
        h[TRC_HDR_OVF_BIT] = ovf;
        h[TRC_HDR_KIND_MSB:TRC_HDR_KIND_LSB] = kind;
        h[TRC_HDR_IDX_MSB:TRC_HDR_IDX_LSB] = idx;
        h[TRC_HDR_SEQ_MSB:TRC_HDR_SEQ_LSB] = seq;
        return h;
    endfunction

    function automatic logic [2:0] first_slot(input logic [5:0] f);
        logic [2:0] s;
        s = SLOT_GPR;
        for (int i = 5; i >= 0; i--) begin
            if (f[i]) s = 3'(i);
        end
        return s;
    endfunction

    function automatic logic [2:0] slot_kind(input logic [2:0] slot);
        logic [2:0] k;
        case (slot)
            SLOT_GPR:             k = TRC_KIND_GPR;
            SLOT_CR:              k = TRC_KIND_CR;
            SLOT_MSR:             k = TRC_KIND_MSR;
            SLOT_SPR0, SLOT_SPR1: k = TRC_KIND_SPR;
            default:              k = TRC_KIND_DM;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ppc_wb_trace_tx_fifo.sv
// Bundle FIFO; a push while full is still taken when a pop happens in the same cycle.
module ppc_wb_trace_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          wr_s;
    logic          rd_s;

    assign full  = (count_r == (AW+1)'(DEPTH));
    assign empty = (count_r == '0);
    assign rdata = mem_r[rd_ptr_r];

    // Qualify requests against occupancy.
    always_comb begin
        rd_s = pop & ~empty;
        wr_s = push & (~full | rd_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (rd_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({wr_s, rd_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (wr_s) mem_r[wr_ptr_r] <= wdata;
    end
endmodule

// File: rtl/ppc_wb_trace_tx.sv
// Captures per-cycle architectural writes as bundles and serialises them as trace records
// on a 32-bit valid/ready stream.
module ppc_wb_trace_tx
    import ppc_wb_trace_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_W      = 16,
    parameter int SPR_AW     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trc_en,
    input  logic [31:0]       instr_w,
    input  logic [31:0]       instr_m,
    input  logic              gpr_wr,
    input  logic [4:0]        gpr_waddr,
    input  logic [31:0]       gpr_wd,
    input  logic              cr_wr,
    input  logic [31:0]       cr_wd,
    input  logic              msr_wr,
    input  logic [31:0]       msr_wd,
    input  logic              spr_wr0,
    input  logic [SPR_AW-1:0] spr_waddr0,
    input  logic [31:0]       spr_wd0,
    input  logic              spr_wr1,
    input  logic [SPR_AW-1:0] spr_waddr1,
    input  logic [31:0]       spr_wd1,
    input  logic              dm_wr,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wd,
    output logic              trc_valid,
    input  logic              trc_ready,
    output logic [31:0]       trc_data,
    output logic [7:0]        trc_drops
);
    trc_bundle_t          cap_s, fifo_rd_s, work_r, nxt_s;
    trc_state_t           state_r;
    logic [2:0]           cur_r, nxt_slot_s;
    logic [SEQ_W-1:0]     seq_r;
    logic                 ovf_r;
    logic                 cap_req_s, fifo_full_s, fifo_empty_s;
    logic                 pop_s, drop_s, rec_done_s, load_s;
    logic [5:0]           rem_flags_s;
    logic [TRC_IDX_W-1:0] nxt_idx_s;
    logic [31:0]          instr_s, val_s, nxt_hdr_s;

    // Assemble this cycle's write-port snapshot.
    always_comb begin
        cap_s.flags      = {dm_wr, spr_wr1, spr_wr0, msr_wr, cr_wr, gpr_wr};
        cap_s.instr_w    = instr_w;
        cap_s.instr_m    = instr_m;
        cap_s.gpr_waddr  = gpr_waddr;
        cap_s.gpr_wd     = gpr_wd;
        cap_s.cr_wd      = cr_wd;
        cap_s.msr_wd     = msr_wd;
        cap_s.spr_waddr0 = TRC_IDX_W'(spr_waddr0);
        cap_s.spr_wd0    = spr_wd0;
        cap_s.spr_waddr1 = TRC_IDX_W'(spr_waddr1);
        cap_s.spr_wd1    = spr_wd1;
        cap_s.dm_addr    = dm_addr;
        cap_s.dm_wd      = dm_wd;
        cap_req_s        = trc_en & (|cap_s.flags);
    end

    ppc_wb_trace_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(TRC_BUNDLE_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap_req_s),
        .wdata (cap_s),
        .pop   (pop_s),
        .rdata (fifo_rd_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Record-boundary decisions and selection of the next record to present.
    always_comb begin
        rem_flags_s = work_r.flags & ~(6'd1 << cur_r);
        rec_done_s  = trc_valid & trc_ready &
                      (((state_r == ST_VAL) & (cur_r != SLOT_DM)) | (state_r == ST_ADDR));
        pop_s       = ~fifo_empty_s & ((state_r == ST_IDLE) | (rec_done_s & (rem_flags_s == 6'd0)));
        drop_s      = cap_req_s & fifo_full_s & ~pop_s;
        load_s      = pop_s | (rec_done_s & (rem_flags_s != 6'd0));
        if (pop_s) begin
            nxt_s = fifo_rd_s;
        end else begin
            nxt_s       = work_r;
            nxt_s.flags = rem_flags_s;
        end
        nxt_slot_s = first_slot(nxt_s.flags);
        case (nxt_slot_s)
            SLOT_GPR:  nxt_idx_s = TRC_IDX_W'(nxt_s.gpr_waddr);
            SLOT_SPR0: nxt_idx_s = nxt_s.spr_waddr0;
            SLOT_SPR1: nxt_idx_s = nxt_s.spr_waddr1;
            default:   nxt_idx_s = {TRC_IDX_W{1'b0}};
        endcase
        nxt_hdr_s = make_hdr(ovf_r, slot_kind(nxt_slot_s), nxt_idx_s, 16'(seq_r));
        instr_s   = (cur_r == SLOT_DM) ? work_r.instr_m : work_r.instr_w;
        case (cur_r)
            SLOT_GPR:  val_s = work_r.gpr_wd;
            SLOT_CR:   val_s = work_r.cr_wd;
            SLOT_MSR:  val_s = work_r.msr_wd;
            SLOT_SPR0: val_s = work_r.spr_wd0;
            SLOT_SPR1: val_s = work_r.spr_wd1;
            default:   val_s = work_r.dm_wd;
        endcase
    end

    // Serialiser: the registered word only changes when idle or on an accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            work_r    <= '0;
            cur_r     <= SLOT_GPR;
            seq_r     <= '0;
            trc_valid <= 1'b0;
            trc_data  <= 32'd0;
        end else if (load_s) begin
            state_r   <= ST_HDR;
            work_r    <= nxt_s;
            cur_r     <= nxt_slot_s;
            trc_valid <= 1'b1;
            trc_data  <= nxt_hdr_s;
        end else if (rec_done_s) begin
            state_r      <= ST_IDLE;
            work_r.flags <= 6'd0;
            trc_valid    <= 1'b0;
            trc_data     <= 32'd0;
        end else if (trc_valid & trc_ready) begin
            case (state_r)
                ST_HDR: begin
                    state_r  <= ST_INSTR;
                    trc_data <= instr_s;
                    seq_r    <= seq_r + SEQ_W'(1);
                end
                ST_INSTR: begin
                    state_r  <= ST_VAL;
                    trc_data <= val_s;
                end
                ST_VAL: begin
                    state_r  <= ST_ADDR;
                    trc_data <= work_r.dm_addr;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    trc_valid <= 1'b0;
                    trc_data  <= 32'd0;
                end
            endcase
        end
    end

    // Drop accounting; a drop coinciding with a header load stays pending for the following header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r     <= 1'b0;
            trc_drops <= 8'd0;
        end else begin
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (load_s) begin
                ovf_r <= 1'b0;
            end
            if (drop_s && (trc_drops != 8'hFF)) begin
                trc_drops <= trc_drops + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_ppc_wb_trace_tx.sv
// Directed bench for ppc_wb_trace_tx: a record-queue model checked every cycle plus literal vectors.
module tb_ppc_wb_trace_tx;
    localparam int FIFO_DEPTH = 4;
    localparam int SEQ_W      = 5;
    localparam int SPR_AW     = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic trc_en = 1'b0;
    logic [31:0] instr_w = 32'd0, instr_m = 32'd0;
    logic gpr_wr = 1'b0, cr_wr = 1'b0, msr_wr = 1'b0, spr_wr0 = 1'b0, spr_wr1 = 1'b0, dm_wr = 1'b0;
    logic [4:0] gpr_waddr = 5'd0;
    logic [31:0] gpr_wd = 32'd0, cr_wd = 32'd0, msr_wd = 32'd0, spr_wd0 = 32'd0, spr_wd1 = 32'd0;
    logic [SPR_AW-1:0] spr_waddr0 = '0, spr_waddr1 = '0;
    logic [31:0] dm_addr = 32'd0, dm_wd = 32'd0;
    logic trc_valid, trc_ready = 1'b0;
    logic [31:0] trc_data;
    logic [7:0] trc_drops;

    int n_chk = 0;
    int n_fail = 0;

    ppc_wb_trace_tx #(.FIFO_DEPTH(FIFO_DEPTH), .SEQ_W(SEQ_W), .SPR_AW(SPR_AW)) dut (
        .clk(clk), .rst_n(rst_n), .trc_en(trc_en), .instr_w(instr_w), .instr_m(instr_m),
        .gpr_wr(gpr_wr), .gpr_waddr(gpr_waddr), .gpr_wd(gpr_wd),
        .cr_wr(cr_wr), .cr_wd(cr_wd), .msr_wr(msr_wr), .msr_wd(msr_wd),
        .spr_wr0(spr_wr0), .spr_waddr0(spr_waddr0), .spr_wd0(spr_wd0),
        .spr_wr1(spr_wr1), .spr_waddr1(spr_waddr1), .spr_wd1(spr_wd1),
        .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_data(trc_data), .trc_drops(trc_drops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: flat queue of expected words; front word is on the bus while m_active.
    typedef struct {
        logic [31:0] data;
        bit          hdr;
        bit          last;
    } word_t;

    word_t m_q[$];
    word_t m_tmp;
    bit    m_active = 0;
    bit    m_start, m_new, m_last;
    bit    m_ovf = 0;
    int    m_waiting = 0;
    int    m_rec = 0;
    int    m_drops = 0;
    logic [31:0] acc_log[$];

    function automatic logic [31:0] hdr_word(input int kind, input int idx, input int rec);
        logic [31:0] h;
        int s;
        s = rec % (1 << SEQ_W);
        h = 32'd0;
        h[30:28] = 3'(kind);
        h[27:18] = 10'(idx);
        h[15:0]  = 16'(s);
        return h;
    endfunction

    task automatic add_rec(input int kind, input int idx, input logic [31:0] ins,
                           input logic [31:0] val, input logic [31:0] adr, input bit has_adr);
        m_q.push_back('{hdr_word(kind, idx, m_rec), 1'b1, 1'b0});
        m_q.push_back('{ins, 1'b0, 1'b0});
        m_q.push_back('{val, 1'b0, 1'b0});
        if (has_adr) m_q.push_back('{adr, 1'b0, 1'b0});
        m_rec++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_active = 0; m_ovf = 0; m_waiting = 0; m_rec = 0; m_drops = 0;
        end else begin
            m_start = 0; m_new = 0;
            if (m_active && trc_ready) begin
                m_last = m_q[0].last;
                void'(m_q.pop_front());
                m_new = 1;
                if (m_last) begin
                    m_active = 0;
                    if (m_waiting > 0) m_start = 1;
                end
            end else if (!m_active && m_waiting > 0) begin
                m_start = 1;
            end
            if (m_start) begin
                m_active = 1; m_waiting--; m_new = 1;
            end
            if (m_active && m_new && m_q[0].hdr) begin
                m_tmp = m_q[0]; m_tmp.data[31] = m_ovf; m_q[0] = m_tmp;
                m_ovf = 0;
            end
            if (trc_en && (gpr_wr || cr_wr || msr_wr || spr_wr0 || spr_wr1 || dm_wr)) begin
                if (m_waiting == FIFO_DEPTH && !m_start) begin
                    m_drops = (m_drops == 255) ? 255 : m_drops + 1;
                    m_ovf = 1;
                end else begin
                    if (gpr_wr)  add_rec(0, int'(gpr_waddr), instr_w, gpr_wd, 32'd0, 0);
                    if (cr_wr)   add_rec(1, 0, instr_w, cr_wd, 32'd0, 0);
                    if (msr_wr)  add_rec(2, 0, instr_w, msr_wd, 32'd0, 0);
                    if (spr_wr0) add_rec(3, int'(spr_waddr0), instr_w, spr_wd0, 32'd0, 0);
                    if (spr_wr1) add_rec(3, int'(spr_waddr1), instr_w, spr_wd1, 32'd0, 0);
                    if (dm_wr)   add_rec(4, 0, instr_m, dm_wd, dm_addr, 1);
                    m_tmp = m_q[m_q.size()-1]; m_tmp.last = 1; m_q[m_q.size()-1] = m_tmp;
                    m_waiting++;
                end
            end
        end
    end

    // Log of words the DUT handed over, for the literal vectors.
    always @(posedge clk) begin
        if (rst_n && trc_valid && trc_ready) acc_log.push_back(trc_data);
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 32'(trc_valid), 32'(m_active));
            if (m_active) chk("data", trc_data, m_q[0].data);
            chk("drops", 32'(trc_drops), 32'(m_drops));
        end
    end

    function automatic logic [31:0] log_at(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 32'hxxxxxxxx;
    endfunction

    task automatic clear_wr();
        gpr_wr = 1'b0; cr_wr = 1'b0; msr_wr = 1'b0; spr_wr0 = 1'b0; spr_wr1 = 1'b0; dm_wr = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cap_gpr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] ins);
        @(negedge clk);
        gpr_wr = 1'b1; gpr_waddr = a; gpr_wd = d; instr_w = ins;
        @(negedge clk);
        clear_wr();
    endtask

    task automatic wait_data(input logic [31:0] v, input string name);
        int n;
        n = 0;
        while (!(trc_valid === 1'b1 && trc_data === v) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 50), 32'd1);
    endtask

    initial begin
        tick(3);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(trc_valid), 32'd0);
        chk("rst_data", trc_data, 32'd0);
        chk("rst_drops", 32'(trc_drops), 32'd0);
        trc_en = 1'b1; trc_ready = 1'b1;

        // Single GPR write: header two edges after capture, then three back-to-back words.
        cap_gpr(5'd3, 32'h12345678, 32'h7C632214);
        chk("gpr_lat_idle", 32'(trc_valid), 32'd0);
        @(negedge clk);
        chk("gpr_lat_hdr", trc_data, 32'h000C0000);
        tick(6);
        chk("gpr_n", acc_log.size(), 32'd3);
        chk("gpr_w0", log_at(0), 32'h000C0000);
        chk("gpr_w1", log_at(1), 32'h7C632214);
        chk("gpr_w2", log_at(2), 32'h12345678);

        // DM write: four-word record.
        acc_log.delete();
        @(negedge clk);
        dm_wr = 1'b1; dm_addr = 32'h00003004; dm_wd = 32'hDEADBEEF; instr_m = 32'h9421FFF0;
        @(negedge clk);
        clear_wr();
        tick(8);
        chk("dm_n", acc_log.size(), 32'd4);
        chk("dm_w0", log_at(0), 32'h40000001);
        chk("dm_w1", log_at(1), 32'h9421FFF0);
        chk("dm_w2", log_at(2), 32'hDEADBEEF);
        chk("dm_w3", log_at(3), 32'h00003004);

        // All six ports in one cycle.
        acc_log.delete();
        @(negedge clk);
        gpr_wr = 1'b1; gpr_waddr = 5'd5; gpr_wd = 32'h11111111;
        cr_wr = 1'b1; cr_wd = 32'h22222222; msr_wr = 1'b1; msr_wd = 32'h33333333;
        spr_wr0 = 1'b1; spr_waddr0 = 10'h110; spr_wd0 = 32'h44444444;
        spr_wr1 = 1'b1; spr_waddr1 = 10'h3FF; spr_wd1 = 32'h55555555;
        dm_wr = 1'b1; dm_addr = 32'h00003008; dm_wd = 32'h66666666;
        instr_w = 32'h7C0903A6; instr_m = 32'h90010008;
        @(negedge clk);
        clear_wr();
        tick(25);
        chk("all_n", acc_log.size(), 32'd19);
        chk("all_gpr_hdr", log_at(0), 32'h00140002);
        chk("all_cr_hdr", log_at(3), 32'h10000003);
        chk("all_spr0_hdr", log_at(9), 32'h34400005);
        chk("all_spr1_hdr", log_at(12), 32'h3FFC0006);
        chk("all_dm_hdr", log_at(15), 32'h40000007);
        chk("all_dm_instr", log_at(16), 32'h90010008);
        chk("all_dm_addr", log_at(18), 32'h00003008);

        // Stall on VAL, overfill the FIFO by one bundle.
        cap_gpr(5'd4, 32'hCAFE0001, 32'h38600001);
        wait_data(32'hCAFE0001, "ovf_reach_val");
        trc_ready = 1'b0;
        gpr_wr = 1'b1; gpr_waddr = 5'd1;
        for (int i = 0; i < 5; i++) begin
            gpr_wd = 32'h00001000 + 32'(i); instr_w = 32'h60000000 + 32'(i);
            @(negedge clk);
        end
        clear_wr();
        tick(5);
        chk("hold_data", trc_data, 32'hCAFE0001);
        chk("ovf_drops", 32'(trc_drops), 32'd1);
        acc_log.delete();
        trc_ready = 1'b1;
        tick(20);
        chk("ovf_val", log_at(0), 32'hCAFE0001);
        chk("ovf_hdr", log_at(1), 32'h80040009);

        // Long drop burst saturates the counter.
        trc_ready = 1'b0;
        gpr_wr = 1'b1; gpr_waddr = 5'd2;
        for (int i = 0; i < 305; i++) begin
            gpr_wd = 32'(i);
            @(negedge clk);
        end
        clear_wr();
        tick(2);
        chk("drops_sat", 32'(trc_drops), 32'd255);
        trc_ready = 1'b1;
        tick(25);

        // Sequence wrap: records 32 and 33 carry seq 0 and 1.
        acc_log.delete();
        for (int i = 0; i < 16; i++) begin
            cap_gpr(5'd7, 32'hA0000000 + 32'(i), 32'h7CE00000);
            tick(2);
        end
        tick(10);
        chk("wrap_seq0", log_at(42), 32'h001C0000);
        chk("wrap_seq1", log_at(45), 32'h001C0001);

        // Reset in the middle of a record.
        cap_gpr(5'd9, 32'hABCD0000, 32'h60000000);
        wait_data(32'h60000000, "rst_reach_instr");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(trc_valid), 32'd0);
        chk("midrst_data", trc_data, 32'd0);
        acc_log.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        cap_gpr(5'd2, 32'h5555AAAA, 32'h7C221378);
        tick(8);
        chk("post_rst_hdr", log_at(0), 32'h00080000);
        chk("post_rst_val", log_at(2), 32'h5555AAAA);
        chk("post_rst_drops", 32'(trc_drops), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
